// File: rtl/row_window_if.sv
// Pixel-in / column-out handshake bundle for row_window_buffer.
// The master drives pixels and out_ready; the slave is the buffer itself.
interface row_window_if #(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned ROWS  = 4
);
    logic                        in_valid;
    logic                        in_ready;
    logic [PIX_W-1:0]            in_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [PIX_W*(ROWS+1)-1:0]   out_col;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_col
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_col
    );
endinterface

// File: rtl/row_window_buffer.sv
// Circular bank of ROWS row memories emitting a vertical (ROWS+1)-pixel column per accepted pixel.
// Optional macro ROW_WINDOW_ZERO_PAD_EN: also emit during priming, zero-filling absent rows.
module row_window_buffer #(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned IMG_W = 64,
    parameter int unsigned IMG_H = 64,
    parameter int unsigned ROWS  = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    row_window_if.slave  bus,
    output logic         complete,
    output logic         busy
);
    localparam int unsigned OW   = PIX_W * (ROWS + 1);
    localparam int unsigned ColW = $clog2(IMG_W);
    localparam int unsigned RowW = $clog2(IMG_H);
    localparam int unsigned PtrW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {StIdle, StPrime, StStream, StDone} state_e;

    state_e           state_q;
    logic [ColW-1:0]  col_q;
    logic [RowW-1:0]  row_q;
    logic [PtrW-1:0]  ptr_q;
    logic             out_valid_q;
    logic [OW-1:0]    out_col_q;
    logic             complete_q;
    logic             busy_q;

    logic [PIX_W-1:0] mem_q [ROWS][IMG_W];

    logic             active;
    logic             accept;
    logic             emit;
    logic             col_last;
    logic [OW-1:0]    window;
    logic [PtrW-1:0]  bank_idx;
    logic [PIX_W-1:0] field;

    assign active       = (state_q == StPrime) || (state_q == StStream);
    assign bus.in_ready = active && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign col_last     = (col_q == ColW'(IMG_W - 1));
    assign bus.out_valid = out_valid_q;
    assign bus.out_col   = out_col_q;
    assign complete      = complete_q;
    assign busy          = busy_q;

`ifdef ROW_WINDOW_ZERO_PAD_EN
    assign emit = 1'b1;
`else
    assign emit = (state_q == StStream);
`endif

    // Field k holds the row k positions above the oldest; bank (ptr+k) mod ROWS is that row.
    always_comb begin
        window   = '0;
        bank_idx = '0;
        field    = '0;
        for (int unsigned k = 0; k < ROWS; k++) begin
            bank_idx = PtrW'((32'(ptr_q) + k) % ROWS);
            field    = mem_q[bank_idx][col_q];
`ifdef ROW_WINDOW_ZERO_PAD_EN
            if ((state_q == StPrime) && (32'(row_q) + k < ROWS)) begin
                field = '0;
            end
`endif
            window[k*PIX_W +: PIX_W] = field;
        end
        window[ROWS*PIX_W +: PIX_W] = bus.in_data;
    end

    // Row storage has no reset; contents are always overwritten before they are used.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[ptr_q][col_q] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            col_q       <= '0;
            row_q       <= '0;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_col_q   <= '0;
            complete_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            if (accept && emit) begin
                out_valid_q <= 1'b1;
                out_col_q   <= window;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            if (accept) begin
                if (col_last) begin
                    col_q <= '0;
                    row_q <= row_q + 1'b1;
                    ptr_q <= (ptr_q == PtrW'(ROWS - 1)) ? '0 : ptr_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StPrime;
                        busy_q  <= 1'b1;
                        col_q   <= '0;
                        row_q   <= '0;
                        ptr_q   <= '0;
                    end
                end
                StPrime: begin
                    if (accept && col_last && (row_q == RowW'(ROWS - 1))) begin
                        state_q <= StStream;
                    end
                end
                StStream: begin
                    if (accept && col_last && (row_q == RowW'(IMG_H - 1))) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                    end
                end
                StDone: begin
                    if (start) begin
                        state_q    <= StPrime;
                        busy_q     <= 1'b1;
                        complete_q <= 1'b0;
                        col_q      <= '0;
                        row_q      <= '0;
                        ptr_q      <= '0;
                    end else if (!out_valid_q) begin
                        complete_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_row_window_buffer.sv
// Randomized bench for row_window_buffer; expected columns come from a whole-frame image model.
module tb_row_window_buffer;
    localparam int PIX_W = 8;
    localparam int IMG_W = 4;
    localparam int IMG_H = 6;
    localparam int ROWS  = 2;
    localparam int OW    = PIX_W * (ROWS + 1);
    localparam int NPIX  = IMG_W * IMG_H;
`ifdef ROW_WINDOW_ZERO_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic start;
    logic complete;
    logic busy;
    int   n_cmp;
    int   n_bad;

    row_window_if #(.PIX_W(PIX_W), .ROWS(ROWS)) bus ();

    row_window_buffer #(
        .PIX_W(PIX_W),
        .IMG_W(IMG_W),
        .IMG_H(IMG_H),
        .ROWS (ROWS)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bus     (bus),
        .complete(complete),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One frame: rnd picks random pixels, vpct/rpct are valid/ready percentages,
    // stall22 holds out_ready low 3 cycles after the 0x22 column, start_at pulses start
    // while that many pixels are in, rst_after resets once that many pixels are in.
    task automatic run_frame(input bit rnd, input int vpct, input int rpct, input bit stall22,
                             input int start_at, input int rst_after);
        logic [PIX_W-1:0] img [IMG_H][IMG_W];
        logic [OW-1:0]    expq [$];
        logic [OW-1:0]    w;
        logic [OW-1:0]    held;
        int               acc, outs, stall, n_exp;
        bit               hold_chk, fin;

        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                img[r][c] = rnd ? PIX_W'($urandom) : PIX_W'(r * 16 + c);
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                if (PAD || r >= ROWS) begin
                    w = '0;
                    for (int k = 0; k <= ROWS; k++)
                        if (r - k >= 0) w[(ROWS-k)*PIX_W +: PIX_W] = img[r-k][c];
                    expq.push_back(w);
                end
        n_exp    = expq.size();
        acc      = 0;
        outs     = 0;
        stall    = 0;
        hold_chk = 1'b0;
        fin      = 1'b0;

        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check_eq("busy_after_start", 64'(busy), 64'd1);
        check_eq("complete_cleared", 64'(complete), 64'd0);

        for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
            if (rst_after >= 0 && acc == rst_after) begin
                rst_n = 1'b0;
                bus.in_valid = 1'b0;
                #1;
                check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
                check_eq("rst_out_col", 64'(bus.out_col), 64'd0);
                check_eq("rst_in_ready", 64'(bus.in_ready), 64'd0);
                check_eq("rst_busy", 64'(busy), 64'd0);
                check_eq("rst_complete", 64'(complete), 64'd0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            bus.in_valid  = (acc < NPIX) && (int'($urandom_range(99)) < vpct);
            bus.in_data   = (acc < NPIX) ? img[acc / IMG_W][acc % IMG_W] : PIX_W'($urandom);
            bus.out_ready = (stall > 0) ? 1'b0 : (int'($urandom_range(99)) < rpct);
            if (stall > 0) stall--;
            start = (start_at >= 0) && (acc == start_at);
            #1;
            if (hold_chk) begin
                check_eq("hold_valid", 64'(bus.out_valid), 64'd1);
                check_eq("hold_col", 64'(bus.out_col), 64'(held));
            end
            hold_chk = 1'b0;
            if (bus.out_valid && !bus.out_ready) begin
                check_eq("bp_in_ready", 64'(bus.in_ready), 64'd0);
                held     = bus.out_col;
                hold_chk = 1'b1;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (expq.size() == 0) begin
                    check_eq("extra_output", 64'(outs), 64'(n_exp - 1));
                end else begin
                    w = expq.pop_front();
                    check_eq("out_col", 64'(bus.out_col), 64'(w));
                    if (!rnd && !PAD && outs == 0) check_eq("first", 64'(bus.out_col), 64'h201000);
                    if (!rnd && !PAD && outs == 1) check_eq("second", 64'(bus.out_col), 64'h211101);
                    if (!rnd && !PAD && outs == 15) check_eq("last", 64'(bus.out_col), 64'h534333);
                    if (!rnd && PAD && outs == 0) check_eq("pad_first", 64'(bus.out_col), 64'h000000);
                    if (!rnd && PAD && outs == 7) check_eq("pad_13", 64'(bus.out_col), 64'h130300);
                    if (!rnd && PAD && outs == 8) check_eq("pad_20", 64'(bus.out_col), 64'h201000);
                    if (stall22 && bus.out_col[ROWS*PIX_W +: PIX_W] == 8'h22) stall = 3;
                end
                outs++;
            end
            if (bus.in_valid && bus.in_ready) acc++;
            if (complete) fin = 1'b1;
            else @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        start         = 1'b0;
        check_eq("frame_done", 64'(fin), 64'd1);
        check_eq("n_outputs", 64'(outs), 64'(n_exp));
        check_eq("n_accepts", 64'(acc), 64'(NPIX));
        check_eq("busy_end", 64'(busy), 64'd0);
        check_eq("valid_end", 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        n_cmp         = 0;
        n_bad         = 0;
        rst_n         = 1'b0;
        start         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        #1;
        check_eq("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("reset_out_col", 64'(bus.out_col), 64'd0);
        check_eq("reset_in_ready", 64'(bus.in_ready), 64'd0);
        check_eq("reset_busy", 64'(busy), 64'd0);
        check_eq("reset_complete", 64'(complete), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_frame(1'b0, 100, 100, 1'b0, -1, -1);
        run_frame(1'b0, 100, 100, 1'b1, -1, -1);
        run_frame(1'b0, 100, 100, 1'b0, 13, -1);
        run_frame(1'b0, 100, 100, 1'b0, -1, 14);
        run_frame(1'b0, 100, 100, 1'b0, -1, -1);
        for (int i = 0; i < 4; i++) run_frame(1'b1, 70, 60, 1'b0, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/row_window_buffer.md
Name: row_window_buffer

Overview:
- Parametrised successor to the current fixed 8-bit-write / 32-bit-read row-buffer top.
- Accepts a raster pixel stream over a valid/ready handshake and stores the last ROWS image rows in a circular bank of row memories.
- For each accepted pixel, emits a vertical column window: the new pixel plus the co-located pixel from each of the ROWS previous rows (PIX_W*(ROWS+1) bits; 40 bits at defaults).
- Feeds the neighbourhood-image-processing (NIP) kernel stage.

Parameters:
PIX_W, 8, bits per pixel
IMG_W, 64, pixels per row (>=2)
IMG_H, 64, rows per frame (>ROWS)
ROWS, 4, buffered previous rows (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin frame; sampled only in IDLE or DONE
in_valid  in  1  input pixel valid
in_ready  out  1  block can accept a pixel this cycle
in_data  in  PIX_W  input pixel, raster order
out_valid  out  1  out_col valid
out_ready  in  1  downstream accepts out_col
out_col  out  PIX_W*(ROWS+1)  column window
complete  out  1  frame finished; level, held until next start
busy  out  1  state is PRIME or STREAM

Behaviour:
- Reset (async, rst_n=0): state IDLE; col, row, bank pointer = 0; out_valid=0, out_col=0, complete=0, busy=0, in_ready=0. Row memory contents are don't-care.
- States:
  - IDLE: on start, go to PRIME with counters cleared.
  - PRIME: active while row<ROWS; on the last pixel of row ROWS-1, go to STREAM.
  - STREAM: on acceptance of pixel (IMG_H-1, IMG_W-1), go to DONE.
  - DONE: complete=1; on start, clear complete and counters and go to PRIME.
  - start is ignored in PRIME and STREAM.
- in_ready = (state is PRIME or STREAM) && (!out_valid || out_ready). Accept = in_valid && in_ready.
- Per accept at (row r, col c):
  - Read bank[(ptr+k) mod ROWS][c] for k=0..ROWS-1 (oldest first), then write in_data into bank[ptr][c]. Read-before-write: the output uses the old value.
  - col increments; at IMG_W-1, col wraps to 0, row increments, and ptr advances mod ROWS, so ptr always names the oldest row.
- out_col packing: [PIX_W*ROWS +: PIX_W] = current pixel (MSB); next field down = row r-1; ...; [0 +: PIX_W] = row r-ROWS (LSB).
- Latency: out_col is registered 1 cycle after accept. out_valid clears on out_ready when no new accept occurs in the same cycle.
- Simultaneous out_ready and accept: the register reloads and out_valid stays 1, giving 1 pixel/clock throughput.
- Without the optional feature, accepts in PRIME update memory but produce no output (out_valid stays 0). The first output is for pixel (ROWS, 0).
- Backpressure: while out_valid=1 and out_ready=0, out_col is held stable and in_ready=0.
- complete rises the cycle after the final output word is consumed (out_valid=0) in DONE.
- Frame pixel count is exactly IMG_W*IMG_H. The width of every counter is derived from $clog2 of its bound.

Optional Feature:
- Macro: ROW_WINDOW_ZERO_PAD_EN.
- Defined: PRIME accepts also emit out_col. Fields for rows that do not exist yet (r-k<0) are forced to 0, so output count per frame = IMG_W*IMG_H.
- Undefined: output count per frame = IMG_W*(IMG_H-ROWS), and no padding logic is built.

Test Plan:
- Params used by all tests: PIX_W=8, IMG_W=4, IMG_H=6, ROWS=2; pixel value = row*16+col; out_ready=1.
- Full frame, no pad: outputs start at pixel 0x20, giving out_col=0x201000. Pixel 0x21 gives 0x211101. Exactly 16 outputs; complete=1 after the last output 0x534333.
- Backpressure: hold out_ready=0 for 3 cycles after the 0x22 output. out_col stays 0x221202, in_ready=0, and no pixel is lost; the next output is 0x231303.
- Reset mid-frame: assert rst_n=0 after pixel 0x31. All outputs zero immediately and state IDLE. After restart, the first output is again 0x201000.
- start ignored while busy: pulse start in STREAM. There is no counter disturbance and all 16 outputs match the expected values.
- Restart from DONE: start clears complete and a second frame produces an identical output sequence, confirming ptr wrap and reuse of stale data.
- With ROW_WINDOW_ZERO_PAD_EN: pixel 0x00 gives 0x000000, 0x13 gives 0x130300, 0x20 gives 0x201000. 24 outputs total.
